morse_receiver: RTL and testbench
=================================

# morse_receiver

- Receives a Morse line driven by the team's Morse transmitter and recovers each letter.
- Measures mark and space run lengths in unit ticks, then classifies each mark as dot or dash and assembles up to four symbols.
- On a letter gap, reports the letter as the same 3-bit letter index the transmitter takes as its opcode (A=000 … H=111).
- Sits between the line input (after synchronisation) and the letter display/LED logic.

## Interface

- DASH_MIN, 2: mark run of at least DASH_MIN ticks is a dash; shorter is a dot.
- LETTER_GAP, 5: space run of LETTER_GAP ticks ends the letter.
- CNT_W, 4: run counter width; counter saturates at 2^CNT_W-1.
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle unit-time enable; din is sampled only when tick=1.
- din  in  1  Morse line, 1=mark, already synchronised to clk.
- letter_valid  out  1  one-cycle pulse, letter_* outputs updated.
- letter_idx  out  3  decoded letter A..H; 000 when letter_err=1.
- letter_code  out  4  symbols, first received in bit 0, 1=dash; unused bits 0.
- letter_len  out  3  symbols received, saturates at 7.
- letter_err  out  1  pattern is not A..H, or more than 4 symbols.
- busy  out  1  state != IDLE.

## Operation

- States:
  - IDLE: waiting for first mark.
  - MARK: counting high ticks.
  - SPACE: counting low ticks after a mark.
- On a tick cycle only:
  - IDLE, din=1: go to MARK, run=1, sym_cnt=0, code=0. IDLE with din=0 stays in IDLE.
  - MARK, din=1: run+1, saturating.
  - MARK, din=0:
    - Classify the mark: dash if run>=DASH_MIN, else dot.
    - If sym_cnt<4, write the symbol to code[sym_cnt].
    - sym_cnt+1, saturating at 7.
    - Go to SPACE with run=1.
  - SPACE, din=1: go to MARK, run=1. This is an inter-element gap.
  - SPACE, din=0: run+1. If run+1 == LETTER_GAP, latch outputs, pulse letter_valid and go to IDLE.
- Decoding: letter_idx comes from a (len, code) lookup.
  - A .- → 000
  - B -... → 001
  - C -.-. → 010
  - D -.. → 011
  - E . → 100
  - F ..-. → 101
  - G --. → 110
  - H .... → 111
  - No match, or len>4: letter_err=1, letter_idx=000.
- letter_idx/code/len/err hold their values until the next letter_valid.
- A mark still running is never terminated by the receiver; a letter ends only through a space.

## Timing

- Reset values: state IDLE, run 0, sym_cnt 0, and all outputs 0 (letter_valid, letter_idx, letter_code, letter_len, letter_err, busy).
- Reset asserted mid-letter discards the partial letter; no letter_valid is produced.
- Latency: letter_valid is registered. It is high in the cycle after the clk edge that samples the LETTER_GAP-th low tick, for exactly one cycle, even if tick stays high.
- din is ignored on non-tick cycles; a glitch between ticks has no effect.
- The transmitter's inter-element gap is 3 ticks, below LETTER_GAP=5, so it must not end a letter. Its dot is 1 tick and its dash 3 ticks.
- A mark longer than the counter range saturates and is still classified as a dash.
- A 5th and later symbol increments letter_len but is not stored; the result is always letter_err=1.
- busy is high from the tick that enters MARK through the tick that returns to IDLE.

## Structure

- Package morse_pkg holds the items shared with the transmitter:
  - letter index constants (A..H);
  - per-letter code and length constants;
  - receiver state encoding;
  - default unit counts for DASH_MIN and LETTER_GAP.
- Sub-module morse_letter_lut: combinational (len[2:0], code[3:0]) → (idx[2:0], hit). The receiver sets letter_err = ~hit | (len>4).
- Run and symbol counters plus the FSM live in morse_receiver.

## Test plan

All scenarios use tick=1 every cycle unless noted.

- Letter A: din 1,0,0,0,1,1,1,0,0,0,0,0 → single letter_valid; idx=000, code=4'b0010, len=3'd2, err=0.
- Letter H: four 1-tick dots separated by 3-tick gaps, then a 5-tick gap → idx=111, code=0000, len=4, err=0.
- Invalid letter O: three dashes (---) → err=1, idx=000, code=0111, len=3.
- Overflow: five dots → err=1, len=5, code=0000, exactly one letter_valid.
- Reset and tick gating:
  - reset asserted after two symbols of a letter → outputs stay 0, busy=0, no letter_valid.
  - tick every 4th cycle with din toggling between ticks → decodes E (code 0, len 1, idx 100).
- Loopback: transmitter driving din for each opcode 000..111 → letter_idx equals the opcode, err=0.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions for the transmitter/receiver pair: letter indices,
// per-letter symbol patterns, receiver state encoding and default unit counts.
package morse_pkg;

    localparam logic [2:0] LETTER_A = 3'd0;
    localparam logic [2:0] LETTER_B = 3'd1;
    localparam logic [2:0] LETTER_C = 3'd2;
    localparam logic [2:0] LETTER_D = 3'd3;
    localparam logic [2:0] LETTER_E = 3'd4;
    localparam logic [2:0] LETTER_F = 3'd5;
    localparam logic [2:0] LETTER_G = 3'd6;
    localparam logic [2:0] LETTER_H = 3'd7;

    // Indexed by letter; first symbol in bit 0, 1 = dash, unused bits 0.
    localparam logic [7:0][3:0] LETTER_CODE = {
        4'b0000, 4'b0011, 4'b0100, 4'b0000,
        4'b0001, 4'b0101, 4'b0001, 4'b0010
    };
    localparam logic [7:0][2:0] LETTER_LEN = {
        3'd4, 3'd3, 3'd4, 3'd1,
        3'd3, 3'd4, 3'd4, 3'd2
    };

    localparam int DASH_MIN_DEF   = 2;
    localparam int LETTER_GAP_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/morse_if.sv
// Line-side inputs and decoded-letter outputs of the Morse receiver.
interface morse_if;
    logic       tick;
    logic       din;
    logic       letter_valid;
    logic [2:0] letter_idx;
    logic [3:0] letter_code;
    logic [2:0] letter_len;
    logic       letter_err;
    logic       busy;

    modport master (
        output tick, din,
        input  letter_valid, letter_idx, letter_code, letter_len, letter_err, busy
    );

    modport slave (
        input  tick, din,
        output letter_valid, letter_idx, letter_code, letter_len, letter_err, busy
    );
endinterface

// File: rtl/morse_letter_lut.sv
// Combinational (len, code) -> letter index lookup against the shared table.
module morse_letter_lut
    import morse_pkg::*;
(
    input  logic [2:0] len,
    input  logic [3:0] code,
    output logic [2:0] idx,
    output logic       hit
);

    always_comb begin
        idx = 3'd0;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (len == LETTER_LEN[i] && code == LETTER_CODE[i]) begin
                idx = 3'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_receiver.sv
// Morse receiver: measures mark/space runs in ticks, classifies dot/dash and
// reports each letter on a letter gap as a registered one-cycle pulse.
module morse_receiver
    import morse_pkg::*;
#(
    parameter int DASH_MIN   = DASH_MIN_DEF,
    parameter int LETTER_GAP = LETTER_GAP_DEF,
    parameter int CNT_W      = 4
) (
    input  logic   clk,
    input  logic   reset,
    morse_if.slave bus
);

    localparam logic [CNT_W-1:0] RUN_MAX  = '1;
    localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DASH_THR = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LETTER_GAP - 1);

    rx_state_t        state, state_n;
    logic [CNT_W-1:0] run, run_n;
    logic [2:0]       sym_cnt, sym_n;
    logic [3:0]       code, code_n;
    logic             emit;

    logic       valid_q, err_q;
    logic [2:0] idx_q, len_q;
    logic [3:0] code_q;

    logic [2:0] lut_idx;
    logic       lut_hit;
    logic       err_n;

    // code/sym_cnt are stable in SPACE, so the lookup sees the finished letter.
    morse_letter_lut u_lut (
        .len  (sym_cnt),
        .code (code),
        .idx  (lut_idx),
        .hit  (lut_hit)
    );

    assign err_n = ~lut_hit | (sym_cnt > 3'd4);

    always_comb begin
        state_n = state;
        run_n   = run;
        sym_n   = sym_cnt;
        code_n  = code;
        emit    = 1'b0;
        if (bus.tick) begin
            unique case (state)
                IDLE: if (bus.din) begin
                    state_n = MARK;
                    run_n   = RUN_ONE;
                    sym_n   = 3'd0;
                    code_n  = 4'd0;
                end
                MARK: if (bus.din) begin
                    run_n = (run == RUN_MAX) ? run : run + RUN_ONE;
                end else begin
                    if (sym_cnt < 3'd4)
                        code_n[sym_cnt[1:0]] = (run >= DASH_THR);
                    sym_n   = (sym_cnt == 3'd7) ? sym_cnt : sym_cnt + 3'd1;
                    state_n = SPACE;
                    run_n   = RUN_ONE;
                end
                SPACE: if (bus.din) begin
                    state_n = MARK;
                    run_n   = RUN_ONE;
                end else if (run == GAP_LAST) begin
                    emit    = 1'b1;
                    state_n = IDLE;
                    run_n   = '0;
                end else begin
                    run_n = run + RUN_ONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            run     <= '0;
            sym_cnt <= 3'd0;
            code    <= 4'd0;
            valid_q <= 1'b0;
            idx_q   <= 3'd0;
            code_q  <= 4'd0;
            len_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            run     <= run_n;
            sym_cnt <= sym_n;
            code    <= code_n;
            valid_q <= emit;
            if (emit) begin
                idx_q  <= err_n ? 3'd0 : lut_idx;
                code_q <= code;
                len_q  <= sym_cnt;
                err_q  <= err_n;
            end
        end
    end

    assign bus.letter_valid = valid_q;
    assign bus.letter_idx   = idx_q;
    assign bus.letter_code  = code_q;
    assign bus.letter_len   = len_q;
    assign bus.letter_err   = err_q;
    assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_morse_receiver.sv
// Scoreboard bench for morse_receiver: directed line patterns push expected
// letters; a monitor pops and compares on every letter_valid.
module tb_morse_receiver;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] code;
        logic [2:0] len;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    morse_if bus ();

    morse_receiver #(.DASH_MIN(2), .LETTER_GAP(5), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Hand-written transmitter patterns, letter A..H in entries 0..7.
    localparam logic [3:0] TX_CODE [8] = '{4'b0010, 4'b0001, 4'b0101, 4'b0001,
                                           4'b0000, 4'b0100, 4'b0011, 4'b0000};
    localparam int         TX_LEN  [8] = '{2, 4, 4, 3, 1, 4, 3, 4};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.letter_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=1 expected=0 at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("letter_idx",  32'(bus.letter_idx),  32'(e.idx));
                    chk("letter_code", 32'(bus.letter_code), 32'(e.code));
                    chk("letter_len",  32'(bus.letter_len),  32'(e.len));
                    chk("letter_err",  32'(bus.letter_err),  32'(e.err));
                end
            end
        end
    end

    task automatic step(input logic t, input logic d);
        @(posedge clk);
        #1;
        bus.tick = t;
        bus.din  = d;
    endtask

    // Sends bits[n-1] first, one per tick, then idles with tick held high.
    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    endtask

    task automatic push(input logic [2:0] idx, input logic [3:0] code,
                        input logic [2:0] len, input logic err);
        exp_t e;
        e.idx = idx; e.code = code; e.len = len; e.err = err;
        sb.push_back(e);
    endtask

    task automatic tx_letter(input int op);
        for (int s = 0; s < TX_LEN[op]; s++) begin
            for (int k = 0; k < (TX_CODE[op][s] ? 3 : 1); k++) step(1'b1, 1'b1);
            if (s < TX_LEN[op] - 1)
                for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        end
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    endtask

    initial begin : stim
        logic [5:0] e_samples;
        reset    = 1'b1;
        bus.tick = 1'b0;
        bus.din  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.letter_valid), 32'd0);
        chk("rst_idx",   32'(bus.letter_idx),   32'd0);
        chk("rst_code",  32'(bus.letter_code),  32'd0);
        chk("rst_len",   32'(bus.letter_len),   32'd0);
        chk("rst_err",   32'(bus.letter_err),   32'd0);
        chk("rst_busy",  32'(bus.busy),         32'd0);
        reset = 1'b0;

        // A: .-
        push(3'b000, 4'b0010, 3'd2, 1'b0);
        send_bits(32'b1000_1110_0000, 12);
        // H: .... with 3-tick inter-element gaps
        push(3'b111, 4'b0000, 3'd4, 1'b0);
        send_bits(32'b1000_1000_1000_1_00000, 18);
        // O: --- not in A..H
        push(3'b000, 4'b0111, 3'd3, 1'b1);
        send_bits(32'b111000_111000_111_00000, 20);
        // five dots: fifth symbol counted but not stored
        push(3'b000, 4'b0000, 3'd5, 1'b1);
        send_bits(32'b10_10_10_10_1_00000, 14);
        // 20-tick mark saturates the counter and is still a dash (T, unknown)
        push(3'b000, 4'b0001, 3'd1, 1'b1);
        send_bits({12'd0, 20'hFFFFF} << 5, 25);
        // 4-tick gap is one short of a letter gap: stays one letter (I, unknown)
        push(3'b000, 4'b0000, 3'd2, 1'b1);
        send_bits(32'b1_0000_1_00000, 11);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("hold_len",  32'(bus.letter_len), 32'd2);

        // reset mid-letter after two symbols: no letter, outputs cleared
        for (int i = 7; i >= 0; i--) step(1'b1, 8'b1000_1110 >> i);
        @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_busy", 32'(bus.busy),        32'd0);
        chk("mr_len",  32'(bus.letter_len),  32'd0);
        chk("mr_err",  32'(bus.letter_err),  32'd0);
        chk("mr_code", 32'(bus.letter_code), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        chk("mr_busy_after", 32'(bus.busy), 32'd0);

        // E with tick every 4th cycle and din toggling between ticks
        push(3'b100, 4'b0000, 3'd1, 1'b0);
        e_samples = 6'b100000;
        for (int i = 5; i >= 0; i--) begin
            step(1'b0, ~e_samples[i]);
            step(1'b0,  e_samples[i]);
            step(1'b0, ~e_samples[i]);
            step(1'b1,  e_samples[i]);
        end
        for (int i = 0; i < 8; i++) step(1'b0, i[0]);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

        // loopback through a transmitter model for every opcode
        for (int op = 0; op < 8; op++) begin
            push(3'(op), TX_CODE[op], 3'(TX_LEN[op]), 1'b0);
            tx_letter(op);
        end

        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        @(negedge clk);
        chk("hold_idx", 32'(bus.letter_idx), 32'd7);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
